// File: rtl/pipe_ret_buf.sv
// pipe_ret_buf
//   Return-side buffer for a fixed-latency, never-stalling compute pipe.
//   Work is issued into the pipe only while credit remains. Results come
//   back PIPE_NUM cycles later and land in a first-word-fall-through FIFO,
//   which is presented downstream with valid/ready handshaking. One credit
//   corresponds to one FIFO entry, so a returning result always has a slot.
//
// Ports
//   clk        clock
//   rst        asynchronous active-high reset
//   in_vld     upstream has work
//   in_rdy     credit available (decoded from the registered credit count)
//   issue      in_vld & in_rdy, drives the pipe's valid input
//   pipe_vld   result valid at the pipe output
//   pipe_data  result data, qualified by pipe_vld
//   out_vld    FIFO not empty
//   out_data   FIFO head
//   out_rdy    downstream accepts the head
//   level      FIFO occupancy
//   err        sticky: [0] write while full, [1] return with nothing in flight
module pipe_ret_buf #(
  parameter int PIPE_NUM = 10,
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  output logic          in_rdy,
  output logic          issue,
  input  logic          pipe_vld,
  input  logic [DW-1:0] pipe_data,
  output logic          out_vld,
  output logic [DW-1:0] out_data,
  input  logic          out_rdy,
  output logic [AW:0]   level,
  output logic [1:0]    err
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

  if (PIPE_NUM < 1) begin : g_bad_pipe_num
    $error("pipe_ret_buf: PIPE_NUM must be at least 1");
  end
  if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_bad_depth
    $error("pipe_ret_buf: DEPTH must be a power of two >= 2 equal to 2**AW");
  end

  logic [AW:0]   cred;
  logic [AW:0]   inflight;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic wr_en;

  // Up/down counter step clamped to 0..CNT_MAX; simultaneous inc and dec cancel.
  // The clamp keeps inflight from underflowing on spurious returns and keeps
  // cred from exceeding DEPTH when spuriously written data is popped.
  function automatic logic [AW:0] sat_step(input logic [AW:0] cur,
                                           input logic        inc,
                                           input logic        dec);
    if (inc && !dec) return (cur == CNT_MAX) ? cur : cur + 1'b1;
    if (dec && !inc) return (cur == '0) ? cur : cur - 1'b1;
    return cur;
  endfunction

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_rdy   = (cred != '0);
  assign issue    = in_vld & in_rdy;
  assign out_vld  = !empty;
  assign pop      = out_vld & out_rdy;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en    = pipe_vld & (!full | pop);
  assign level    = wr_ptr - rd_ptr;
  assign out_data = mem[rd_ptr[AW-1:0]];

  // Control state: credits, in-flight count, pointers, sticky errors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cred     <= CNT_MAX;
      inflight <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      err      <= '0;
    end else begin
      cred     <= sat_step(cred, pop, issue);
      inflight <= sat_step(inflight, issue, pipe_vld);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (pipe_vld && full && !pop) err[0] <= 1'b1;
      if (pipe_vld && inflight == '0) err[1] <= 1'b1;
    end
  end

  // Storage array, data only
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= pipe_data;
  end

endmodule
